// File: rtl/usb_hub_defines_pkg.sv
// Shared USB hub definitions: scheduler state encodings and serial request types.
// Also carries the pre-existing REQUEST_SERIAL_DATA_TYPE_* defines consumed elsewhere in the hub.
`ifndef USB_HUB_DEFINES_SVH
`define USB_HUB_DEFINES_SVH
`define REQUEST_SERIAL_DATA_TYPE_TOKEN     2'd0
`define REQUEST_SERIAL_DATA_TYPE_DATA      2'd1
`define REQUEST_SERIAL_DATA_TYPE_HANDSHAKE 2'd2
`endif

package usb_hub_defines_pkg;

  localparam int USB_SCHED_STATE_W = 3;

  localparam logic [USB_SCHED_STATE_W-1:0] USB_SCHED_STATE_IDLE   = 3'd0;
  localparam logic [USB_SCHED_STATE_W-1:0] USB_SCHED_STATE_ARB    = 3'd1;
  localparam logic [USB_SCHED_STATE_W-1:0] USB_SCHED_STATE_POLL   = 3'd2;
  localparam logic [USB_SCHED_STATE_W-1:0] USB_SCHED_STATE_ACTIVE = 3'd3;
  localparam logic [USB_SCHED_STATE_W-1:0] USB_SCHED_STATE_GAP    = 3'd4;

endpackage

// File: rtl/usb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after i_ptr wins, wrapping.
// Requests masked by i_prio take precedence; pass all-ones for plain round-robin.
module usb_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_prio,
  input  logic [PORT_W-1:0]    i_ptr,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [PORT_W-1:0]    o_id
);

  logic [NUM_PORTS-1:0] w_prio_req;
  logic [NUM_PORTS-1:0] w_cand;

  assign w_prio_req = i_req & i_prio;
  assign w_cand     = (|w_prio_req) ? w_prio_req : i_req;

  always_comb begin : p_pick
    logic [PORT_W-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_grant = '0;
    o_id    = '0;
    idx     = '0;
    // Scan from farthest to nearest so the port closest after the pointer is the last to override.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = PORT_W'((int'(i_ptr) + k) % NUM_PORTS);
      if (w_cand[idx]) begin
        o_grant      = '0;
        o_grant[idx] = 1'b1;
        o_id         = idx;
      end
    end
  end

endmodule

// File: rtl/usb_host_poll_scheduler.sv
// Shares one host USB transceiver among NUM_PORTS requesters: periodic poll, round-robin grant,
// timeout supervision and inter-transaction gap. Optional macro USB_POLL_PRIO_EN adds i_port_prio.
module usb_host_poll_scheduler
  import usb_hub_defines_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_W         = 2,
  parameter int POLL_PERIOD    = 1000,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic [NUM_PORTS-1:0] i_port_req,
  input  logic [NUM_PORTS-1:0] i_port_sdata,
  input  logic [NUM_PORTS-1:0] i_port_sval,
  input  logic [NUM_PORTS-1:0] i_port_slast,
  input  logic [NUM_PORTS-1:0] i_port_savail,
`ifdef USB_POLL_PRIO_EN
  input  logic [NUM_PORTS-1:0] i_port_prio,
`endif
  output logic [NUM_PORTS-1:0] o_port_req_serial,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [PORT_W-1:0]    o_grant_id,
  output logic                 o_poll_pulse,
  output logic                 o_tr_sdata,
  output logic                 o_tr_sval,
  output logic                 o_tr_slast,
  output logic                 o_tr_savail,
  input  logic                 i_tr_req_serial,
  input  logic                 i_tr_done,
  output logic                 o_timeout_err,
  output logic                 o_busy
);

  localparam int POLL_W  = $clog2(POLL_PERIOD);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [USB_SCHED_STATE_W-1:0] r_state;
  logic [POLL_W-1:0]            r_poll_cnt;
  logic [CNT_W-1:0]             r_cnt;
  logic [PORT_W-1:0]            r_ptr;
  logic [NUM_PORTS-1:0]         r_grant;
  logic [PORT_W-1:0]            r_grant_id;
  logic                         r_poll_pulse;
  logic                         r_timeout_err;

  logic [NUM_PORTS-1:0] w_prio;
  logic [NUM_PORTS-1:0] w_arb_grant;
  logic [PORT_W-1:0]    w_arb_id;
  logic                 w_wrap;
  logic                 w_active;
  logic                 w_timeout;
  logic                 w_gap_done;

`ifdef USB_POLL_PRIO_EN
  assign w_prio = i_port_prio;
`else
  assign w_prio = '1;
`endif

  usb_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_arb (
    .i_req   (i_port_req),
    .i_prio  (w_prio),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_id    (w_arb_id)
  );

  assign w_wrap     = i_enable && (r_poll_cnt == POLL_W'(POLL_PERIOD - 1));
  assign w_active   = (r_state == USB_SCHED_STATE_ACTIVE);
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_gap_done = (r_cnt == CNT_W'(GAP_CYCLES - 1));

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= USB_SCHED_STATE_IDLE;
      r_poll_cnt    <= '0;
      r_cnt         <= '0;
      r_ptr         <= PORT_W'(NUM_PORTS - 1);
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_poll_pulse  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_poll_pulse  <= 1'b0;
      r_timeout_err <= 1'b0;

      // Free-running poll timebase; wraps that land outside IDLE are simply ignored.
      if (!i_enable || w_wrap) r_poll_cnt <= '0;
      else                     r_poll_cnt <= r_poll_cnt + POLL_W'(1);

      case (r_state)
        USB_SCHED_STATE_IDLE: begin
          if (w_wrap && (|i_port_req)) r_state <= USB_SCHED_STATE_ARB;
        end
        USB_SCHED_STATE_ARB: begin
          if (|w_arb_grant) begin
            r_grant    <= w_arb_grant;
            r_grant_id <= w_arb_id;
            r_ptr      <= w_arb_id;
            r_state    <= USB_SCHED_STATE_POLL;
          end else begin
            r_state <= USB_SCHED_STATE_IDLE;
          end
        end
        USB_SCHED_STATE_POLL: begin
          r_poll_pulse <= 1'b1;
          r_cnt        <= '0;
          r_state      <= USB_SCHED_STATE_ACTIVE;
        end
        USB_SCHED_STATE_ACTIVE: begin
          // A completion in the final allowed cycle beats the timeout.
          if (i_tr_done || w_timeout) begin
            r_timeout_err <= !i_tr_done;
            r_grant       <= '0;
            r_cnt         <= '0;
            r_state       <= USB_SCHED_STATE_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        USB_SCHED_STATE_GAP: begin
          if (w_gap_done) r_state <= USB_SCHED_STATE_IDLE;
          else            r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: r_state <= USB_SCHED_STATE_IDLE;
      endcase
    end
  end

  always_comb begin
    o_port_req_serial = '0;
    if (w_active) o_port_req_serial[r_grant_id] = i_tr_req_serial;
  end

  assign o_tr_sdata    = w_active & i_port_sdata[r_grant_id];
  assign o_tr_sval     = w_active & i_port_sval[r_grant_id];
  assign o_tr_slast    = w_active & i_port_slast[r_grant_id];
  assign o_tr_savail   = w_active & i_port_savail[r_grant_id];
  assign o_grant       = r_grant;
  assign o_grant_id    = r_grant_id;
  assign o_poll_pulse  = r_poll_pulse;
  assign o_timeout_err = r_timeout_err;
  assign o_busy        = (r_state != USB_SCHED_STATE_IDLE);

endmodule

// File: tb/tb_usb_host_poll_scheduler.sv
// Self-checking bench for usb_host_poll_scheduler: timeline model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_usb_host_poll_scheduler;

  localparam int N   = 4;
  localparam int PW  = 2;
  localparam int P   = 16;
  localparam int TO  = 255;
  localparam int GAP = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [N-1:0]  port_req = '0;
  logic [N-1:0]  port_sdata = '0;
  logic [N-1:0]  port_sval = '0;
  logic [N-1:0]  port_slast = '0;
  logic [N-1:0]  port_savail = '0;
`ifdef USB_POLL_PRIO_EN
  logic [N-1:0]  port_prio = '0;
`endif
  logic          tr_req_serial = 1'b0;
  logic          tr_done = 1'b0;
  logic [N-1:0]  port_req_serial;
  logic [N-1:0]  grant;
  logic [PW-1:0] grant_id;
  logic          poll_pulse, tr_sdata, tr_sval, tr_slast, tr_savail, timeout_err, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  usb_host_poll_scheduler #(
    .NUM_PORTS(N), .PORT_W(PW), .POLL_PERIOD(P), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .i_enable          (enable),
    .i_port_req        (port_req),
    .i_port_sdata      (port_sdata),
    .i_port_sval       (port_sval),
    .i_port_slast      (port_slast),
    .i_port_savail     (port_savail),
`ifdef USB_POLL_PRIO_EN
    .i_port_prio       (port_prio),
`endif
    .o_port_req_serial (port_req_serial),
    .o_grant           (grant),
    .o_grant_id        (grant_id),
    .o_poll_pulse      (poll_pulse),
    .o_tr_sdata        (tr_sdata),
    .o_tr_sval         (tr_sval),
    .o_tr_slast        (tr_slast),
    .o_tr_savail       (tr_savail),
    .i_tr_req_serial   (tr_req_serial),
    .i_tr_done         (tr_done),
    .o_timeout_err     (timeout_err),
    .o_busy            (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a transaction is described by its age since arbitration (0=arb, 1=poll, >=2 active)
  // and the number of gap cycles still owed afterwards.
  int            m_age = -1;
  int            m_gap = 0;
  int            m_pcnt = 0;
  logic [PW-1:0] m_port = '0;
  logic [PW-1:0] m_ptr = PW'(N - 1);
  logic          m_to = 1'b0;
  logic          m_live = 1'b0;
  logic          m_wrap;
  logic [N-1:0]  m_prio;

  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req, input logic [N-1:0] prio,
                                            input logic [PW-1:0] ptr);
    logic [N-1:0] cand;
    cand = ((req & prio) != '0) ? (req & prio) : req;
    for (int k = 1; k <= N; k++)
      if (cand[(int'(ptr) + k) % N]) return PW'((int'(ptr) + k) % N);
    return ptr;
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      m_live = 1'b1;
`ifdef USB_POLL_PRIO_EN
      m_prio = port_prio;
`else
      m_prio = '1;
`endif
      if (reset) begin
        m_age = -1; m_gap = 0; m_pcnt = 0; m_ptr = PW'(N - 1); m_to = 1'b0; m_port = '0;
      end else begin
        m_to   = 1'b0;
        m_wrap = enable && (m_pcnt == P - 1);
        m_pcnt = enable ? (m_pcnt + 1) % P : 0;
        if (m_gap > 0) m_gap--;
        else if (m_age < 0) begin
          if (m_wrap && port_req != '0) m_age = 0;
        end else if (m_age == 0) begin
          if (port_req == '0) m_age = -1;
          else begin
            m_port = rr_pick(port_req, m_prio, m_ptr);
            m_ptr  = m_port;
            m_age  = 1;
          end
        end else if (m_age >= 2 && tr_done) begin
          m_age = -1; m_gap = GAP;
        end else if (m_age >= 2 && (m_age - 2) == TO - 1) begin
          m_age = -1; m_gap = GAP; m_to = 1'b1;
        end else m_age++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (m_live) begin
        check("grant", grant, (m_age >= 1) ? (N'(1) << m_port) : '0);
        if (m_age >= 1) check("grant_id", grant_id, m_port);
        check("busy", busy, (m_age >= 0) || (m_gap > 0));
        check("poll_pulse", poll_pulse, m_age == 2);
        check("timeout_err", timeout_err, m_to);
        check("tr_sdata", tr_sdata, (m_age >= 2) ? port_sdata[m_port] : 1'b0);
        check("tr_sval", tr_sval, (m_age >= 2) ? port_sval[m_port] : 1'b0);
        check("tr_slast", tr_slast, (m_age >= 2) ? port_slast[m_port] : 1'b0);
        check("tr_savail", tr_savail, (m_age >= 2) ? port_savail[m_port] : 1'b0);
        check("port_req_serial", port_req_serial,
              (m_age >= 2) ? (N'(tr_req_serial) << m_port) : '0);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int max_cyc, output int n);
    n = 0;
    while (grant == '0 && n < max_cyc) begin
      step();
      n++;
    end
    if (grant == '0) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_grant: no grant within %0d cycles", max_cyc);
    end
  endtask

  task automatic finish_txn(input int active_cycles);
    step(active_cycles);
    tr_done = 1'b1;
    step();
    tr_done = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int n);
    n = 0;
    while (busy && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    logic [N-1:0] seq [5];

    // Reset state and single-port transaction.
    enable   = 1'b1;
    port_req = 4'b0001;
    do_reset();
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    wait_grant(40, n);
    check("t1_grant_latency", n, 17);
    check("t1_grant", grant, 4'b0001);
    check("t1_no_pulse_yet", poll_pulse, 0);
    port_req = '0;
    step();
    check("t1_poll_pulse", poll_pulse, 1);
    step();
    check("t1_poll_pulse_single", poll_pulse, 0);
    tr_done = 1'b1;
    step();
    tr_done = 1'b0;
    check("t1_grant_cleared", grant, 4'b0000);
    check("t1_busy_in_gap", busy, 1);
    wait_idle(20, n);
    check("t1_gap_len", n, 8);

    // All ports requesting: round-robin order, grants aligned to poll boundaries.
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    port_req = 4'b1111;
    do_reset();
    t0 = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(100, n);
      check("t2_rr_grant", grant, seq[i]);
      if (i == 0) t0 = cyc;
      else check("t2_poll_boundary", (cyc - t0) % P, 0);
      finish_txn(20);
    end

    // Timeout on port 2, then the other pending ports go first.
    seq = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
    port_req = 4'b0100;
    do_reset();
    wait_grant(40, n);
    check("t3_grant", grant, 4'b0100);
    port_req = 4'b1111;
    step();
    check("t3_active_entry", poll_pulse, 1);
    n = 0;
    while (!timeout_err && n < 300) begin
      step();
      n++;
    end
    check("t3_timeout_latency", n, 255);
    check("t3_grant_dropped", grant, 4'b0000);
    step();
    check("t3_timeout_single", timeout_err, 0);
    for (int i = 0; i < 4; i++) begin
      wait_grant(100, n);
      check("t3_after_timeout", grant, seq[i]);
      finish_txn(3);
    end

    // Stream mux on port 1.
    port_req = 4'b0010;
    do_reset();
    wait_grant(40, n);
    port_req = '0;
    step();
    port_sdata = 4'b0010;
    #1 check("t4_sdata_hi", tr_sdata, 1);
    port_sdata = 4'b0001;
    #1 check("t4_sdata_other", tr_sdata, 0);
    port_sval = 4'b0010; port_slast = 4'b0010; port_savail = 4'b1101; tr_req_serial = 1'b1;
    #1;
    check("t4_sval", tr_sval, 1);
    check("t4_slast", tr_slast, 1);
    check("t4_savail", tr_savail, 0);
    check("t4_req_serial", port_req_serial, 4'b0010);
    step();
    tr_req_serial = 1'b0;
    port_sdata = '0; port_sval = '0; port_slast = '0; port_savail = '0;
    finish_txn(2);
    wait_idle(20, n);

    // Reset five clocks into ACTIVE.
    port_req = 4'b0100;
    port_sdata = 4'b1111;
    do_reset();
    wait_grant(40, n);
    step(6);
    reset = 1'b1;
    step();
    check("t5_rst_grant", grant, 4'b0000);
    check("t5_rst_sdata", tr_sdata, 0);
    check("t5_rst_busy", busy, 0);
    reset = 1'b0;
    port_sdata = '0;
    port_req = 4'b1111;
    wait_grant(40, n);
    check("t5_first_after_reset", grant, 4'b0001);
    finish_txn(2);
    wait_idle(20, n);

    // Enable dropped mid-transaction: completes through GAP, then holds IDLE.
    port_req = 4'b0010;
    do_reset();
    wait_grant(40, n);
    enable = 1'b0;
    finish_txn(4);
    wait_idle(20, n);
    check("t6_gap_len", n, 8);
    step(3 * P);
    check("t6_held_grant", grant, 4'b0000);
    check("t6_held_busy", busy, 0);
    enable = 1'b1;

`ifdef USB_POLL_PRIO_EN
    seq = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    port_req  = 4'b1111;
    port_prio = 4'b0100;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) port_prio = '0;
      wait_grant(100, n);
      check("t7_prio_grant", grant, seq[i]);
      finish_txn(2);
    end
`endif

    port_req = '0;
    step(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_host_poll_scheduler.md
Name: usb_host_poll_scheduler

Overview:
Sequences and shares the single host-side USB transceiver between NUM_PORTS downstream requesters (hub ports / endpoint pollers).
- Generates the transceiver's polling pulse at a programmable interval.
- Arbitrates round-robin among pending ports and muxes the granted port's PISO serial stream into the transceiver.
- Supervises each transaction with a timeout, then enforces an inter-transaction gap before the next grant.

Parameters:
NUM_PORTS, 4, number of requesting ports (2..8)
PORT_W, 2, width of grant index; must equal clog2(NUM_PORTS)
POLL_PERIOD, 1000, clocks between polling opportunities (>=4)
TIMEOUT_CYCLES, 255, max clocks a granted transaction may stay ACTIVE
GAP_CYCLES, 8, idle clocks between transactions (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scheduler enable; 0 holds FSM in IDLE with counter cleared
port_req  in  NUM_PORTS  per-port transaction request, level, held until grant
port_sdata  in  NUM_PORTS  per-port serial data bit
port_sval  in  NUM_PORTS  per-port serial data valid
port_slast  in  NUM_PORTS  per-port last-bit-of-field flag
port_savail  in  NUM_PORTS  per-port payload-available flag
port_req_serial  out  NUM_PORTS  transceiver request_serial_data routed to the granted port only
grant  out  NUM_PORTS  one-hot grant, 0 when no grant
grant_id  out  PORT_W  index of granted port, valid while grant!=0
poll_pulse  out  1  one-clock polling pulse to transceiver polling_clock
tr_sdata / tr_sval / tr_slast / tr_savail  out  1 each  muxed stream to transceiver serial_data_in*
tr_req_serial  in  1  transceiver request_serial_data
tr_done  in  1  one-clock pulse: transceiver finished the transaction (response complete)
timeout_err  out  1  one-clock pulse on transaction timeout
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: grant=0, grant_id=0, poll_pulse=0, timeout_err=0, busy=0, all tr_* =0, port_req_serial=0, state=IDLE, poll counter=0, rr pointer=NUM_PORTS-1 (port 0 wins first).
- FSM states: IDLE, ARB, POLL, ACTIVE, GAP.
- IDLE: poll counter increments each clock while enable=1.
  - At POLL_PERIOD-1 the counter wraps to 0.
  - If port_req!=0 at the wrap, go to ARB. Otherwise stay in IDLE; the opportunity is lost and the next check is POLL_PERIOD later.
- ARB, 1 clock: round-robin pick of the first set port_req bit strictly after the rr pointer, wrapping. Registers grant/grant_id, updates the rr pointer to the winner, goes to POLL.
- POLL, 1 clock: poll_pulse=1, then go to ACTIVE. Grant is held.
- ACTIVE:
  - tr_* = granted port's port_s* (combinational mux from registered grant_id).
  - port_req_serial[grant_id] = tr_req_serial; all other bits 0.
  - Timeout counter counts from 0.
  - tr_done → GAP.
  - Counter reaching TIMEOUT_CYCLES → timeout_err pulse 1 clock, then GAP.
  - tr_done and timeout in the same cycle: tr_done wins, no timeout_err.
- GAP: grant=0 and all tr_*=0 immediately on entry. Counts GAP_CYCLES clocks, then IDLE.
- The poll counter keeps running in ARB/POLL/ACTIVE/GAP. A wrap outside IDLE is dropped, not queued.
- Requester withdrawing port_req after ARB: the transaction still runs to tr_done/timeout.
- enable deasserted mid-transaction: the current transaction completes through GAP, then IDLE holds.
- reset mid-ACTIVE: all outputs return to reset values on the next edge.
- Outside ACTIVE, tr_* and port_req_serial are 0.
- Latency from poll-counter wrap with a request pending to poll_pulse: 2 clocks.

Optional Feature:
USB_POLL_PRIO_EN
- With the macro: adds input port_prio[NUM_PORTS]. In ARB, requesting ports with port_prio=1 are arbitrated round-robin among themselves first; ports with port_prio=0 are considered only when no prioritized request is pending. The rr pointer is shared.
- Without the macro: the port does not exist; plain round-robin.

Decomposition:
- Shared package/header usb_hub_defines:
  - scheduler state encodings (USB_SCHED_STATE_*) and state width
  - existing REQUEST_SERIAL_DATA_TYPE_* defines, reused unchanged
- Sub-module usb_rr_arbiter: parameterized NUM_PORTS.
  - Inputs: req vector, pointer, optional priority mask.
  - Outputs: one-hot winner and index.
  - Purely combinational; the scheduler registers its outputs.

Test Plan:
- port_req=4'b0001, POLL_PERIOD=16 → grant=0001 in the cycle after the counter wrap, poll_pulse exactly 1 clock on the next cycle; tr_done → grant=0 immediately, busy low after 8 GAP clocks.
- port_req=4'b1111 held, tr_done after 20 clocks each → grant sequence 0001,0010,0100,1000,0001; each grant separated by one POLL_PERIOD boundary.
- Granted port 2 with no tr_done, TIMEOUT_CYCLES=255 → timeout_err single pulse 255 clocks after ACTIVE entry; GAP; port 2 may be granted again only after the other pending ports.
- In ACTIVE on port 1, toggle port_sdata[1] and port_sdata[0] → tr_sdata follows bit 1 only; tr_req_serial=1 → port_req_serial=4'b0010.
- reset asserted 5 clocks into ACTIVE → grant=0, tr_*=0, busy=0 on the next edge; the first grant after release goes to port 0.
- USB_POLL_PRIO_EN defined, port_req=1111, port_prio=0100 → port 2 granted on every poll while it keeps requesting; port_prio=0 restores the round-robin order.
